// File: rtl/data_mem_seq.sv
// Single-port data memory with valid/ready access, one-cycle registered reads,
// and a clear engine that writes CLR_VAL to every word after reset or on command.
module data_mem_seq #(
   parameter int                 DATA_W  = 8,
   parameter int                 ADDR_W  = 8,
   parameter int                 DEPTH   = 256,
   parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_write,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_wdata,
   output logic              o_rd_valid,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_err,
   input  logic              i_clear_start,
   output logic              o_busy,
   output logic              o_clear_done
);

   localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_IDLE  = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [ADDR_W-1:0]   r_clr_addr;
   logic [ADDR_W-1:0]   w_clr_addr_next;
   logic [DATA_W-1:0]   r_core [0:DEPTH-1];
   logic                r_rd_valid;
   logic [DATA_W-1:0]   r_rd_data;
   logic                r_err;
   logic                r_clear_done;

   logic                w_accept;
   logic                w_in_range;
   logic                w_clr_last;
   logic                w_we;
   logic [IDX_W-1:0]    w_waddr;
   logic [DATA_W-1:0]   w_wdata;
   logic [DATA_W-1:0]   w_rdata;

   assign o_busy      = (r_state == S_CLEAR);
   assign o_req_ready = (r_state == S_IDLE) && !i_clear_start;
   assign w_accept    = i_req_valid && o_req_ready;
   assign w_in_range  = ({1'b0, i_req_addr} < DEPTH_L);
   assign w_clr_last  = (r_clr_addr == LAST_ADDR);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_CLEAR;
         r_clr_addr <= '0;
      end else begin
         r_state    <= w_state_next;
         r_clr_addr <= w_clr_addr_next;
      end
   end

   // clear_start is deliberately ignored while a sweep is running
   always_comb begin
      w_state_next    = r_state;
      w_clr_addr_next = r_clr_addr;
      case (r_state)
         S_CLEAR: begin
            if (w_clr_last) begin
               w_state_next    = S_IDLE;
               w_clr_addr_next = '0;
            end else begin
               w_clr_addr_next = r_clr_addr + 1'b1;
            end
         end
         S_IDLE: begin
            if (i_clear_start) begin
               w_state_next = S_CLEAR;
            end
         end
         default: begin
            w_state_next    = S_CLEAR;
            w_clr_addr_next = '0;
         end
      endcase
   end

   // The reset gate keeps the array untouched while the FSM is held in CLEAR.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = i_req_addr[IDX_W-1:0];
      w_wdata = i_req_wdata;
      if (r_state == S_CLEAR) begin
         w_we    = i_rst_n;
         w_waddr = r_clr_addr[IDX_W-1:0];
         w_wdata = CLR_VAL;
      end else if (w_accept && i_req_write && w_in_range) begin
         w_we    = i_rst_n;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_we) begin
         r_core[w_waddr] <= w_wdata;
      end
   end

   assign w_rdata = r_core[i_req_addr[IDX_W-1:0]];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_valid   <= 1'b0;
         r_rd_data    <= '0;
         r_err        <= 1'b0;
         r_clear_done <= 1'b0;
      end else begin
         r_rd_valid   <= w_accept && !i_req_write;
         r_err        <= w_accept && !w_in_range;
         r_clear_done <= (r_state == S_CLEAR) && w_clr_last;
         if (w_accept && !i_req_write) begin
            r_rd_data <= w_in_range ? w_rdata : '0;
         end
      end
   end

   assign o_rd_valid   = r_rd_valid;
   assign o_rd_data    = r_rd_data;
   assign o_err        = r_err;
   assign o_clear_done = r_clear_done;

endmodule

// File: tb/tb_data_mem_seq.sv
// Scoreboard bench for data_mem_seq: a 256-word instance (CLR_VAL=A5) and a
// 200-word instance share one request bus; monitors check outputs against queues.
module tb_data_mem_seq;

   typedef struct {
      int         cyc;
      bit         rv;
      bit         er;
      logic [7:0] d;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a_valid, b_valid, a_clr, b_clr;
   logic       req_write;
   logic [7:0] req_addr, req_wdata;
   logic       a_ready, a_rv, a_err, a_busy, a_cd;
   logic       b_ready, b_rv, b_err, b_busy, b_cd;
   logic [7:0] a_rd, b_rd;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   n;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_mem_seq #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .CLR_VAL(8'hA5)) u_a (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(a_valid), .o_req_ready(a_ready), .i_req_write(req_write),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_rd_valid(a_rv), .o_rd_data(a_rd), .o_err(a_err),
      .i_clear_start(a_clr), .o_busy(a_busy), .o_clear_done(a_cd)
   );

   data_mem_seq #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .CLR_VAL(8'h00)) u_b (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(b_valid), .o_req_ready(b_ready), .i_req_write(req_write),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_rd_valid(b_rv), .o_rd_data(b_rd), .o_err(b_err),
      .i_clear_start(b_clr), .o_busy(b_busy), .o_clear_done(b_cd)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, req, cyc);
      end else begin
         $display("ok   %s value=0x%0h (cycle %0d)", nm, act, cyc);
      end
   endtask

   always @(negedge clk) begin
      while (qa.size() > 0 && qa[0].cyc < cyc) begin
         ea = qa.pop_front();
         chk("A_missing_output_cycle", cyc, ea.cyc);
      end
      if (a_rv || a_err) begin
         if (qa.size() == 0) begin
            chk("A_unexpected_output", {a_rv, a_err}, 2'b00);
         end else begin
            ea = qa.pop_front();
            chk("A_out_cycle", cyc, ea.cyc);
            chk("A_out_rv_err_data", {a_rv, a_err, (a_rv ? a_rd : 8'h00)}, {ea.rv, ea.er, ea.d});
         end
      end
   end

   always @(negedge clk) begin
      while (qb.size() > 0 && qb[0].cyc < cyc) begin
         eb = qb.pop_front();
         chk("B_missing_output_cycle", cyc, eb.cyc);
      end
      if (b_rv || b_err) begin
         if (qb.size() == 0) begin
            chk("B_unexpected_output", {b_rv, b_err}, 2'b00);
         end else begin
            eb = qb.pop_front();
            chk("B_out_cycle", cyc, eb.cyc);
            chk("B_out_rv_err_data", {b_rv, b_err, (b_rv ? b_rd : 8'h00)}, {eb.rv, eb.er, eb.d});
         end
      end
   end

   // Called just after a rising edge; the request is accepted on the next edge.
   task automatic issue(input bit sel, input bit wr, input logic [7:0] addr,
                        input logic [7:0] wd, input bit erv, input bit eerr,
                        input logic [7:0] ed);
      exp_t e;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      a_valid   = !sel;
      b_valid   = sel;
      e.cyc = cyc + 1;
      e.rv  = erv;
      e.er  = eerr;
      e.d   = ed;
      if (erv || eerr) begin
         if (sel) qb.push_back(e);
         else     qa.push_back(e);
      end
      @(negedge clk);
      chk(sel ? "B_req_ready" : "A_req_ready", sel ? b_ready : a_ready, 1);
      @(posedge clk);
      #1;
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   // Counts busy cycles of instance A; optionally pulses clear_start at cycle pulse_at.
   task automatic sweep_count(output int cnt, input int pulse_at);
      int bad;
      cnt = 0;
      bad = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (!a_busy) break;
         cnt++;
         if (a_cd) bad++;
         a_clr = (cnt == pulse_at);
      end
      a_clr = 1'b0;
      chk("A_clear_done_during_sweep", bad, 0);
      chk("A_clear_done_at_end", a_cd, 1);
      chk("A_ready_after_sweep", a_ready, 1);
   endtask

   task automatic chk_reset_a();
      chk("A_rst_busy", a_busy, 1);
      chk("A_rst_ready", a_ready, 0);
      chk("A_rst_rd_valid", a_rv, 0);
      chk("A_rst_rd_data", a_rd, 8'h00);
      chk("A_rst_err", a_err, 0);
      chk("A_rst_clear_done", a_cd, 0);
   endtask

   initial begin
      rst_n = 1'b1;
      a_valid = 1'b0; b_valid = 1'b0; a_clr = 1'b0; b_clr = 1'b0;
      req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_a();

      // Reset release: full 256-word sweep, then a single clear_done pulse
      @(posedge clk); #1 rst_n = 1'b1;
      sweep_count(n, 0);
      chk("A_sweep_len_after_reset", n, 256);
      @(negedge clk);
      chk("A_clear_done_is_pulse", a_cd, 0);
      @(posedge clk); #1;

      issue(0, 0, 8'd0,   8'h00, 1, 0, 8'hA5);
      issue(0, 0, 8'd128, 8'h00, 1, 0, 8'hA5);
      issue(0, 0, 8'd255, 8'h00, 1, 0, 8'hA5);

      // Back-to-back writes then reads, one access per cycle
      issue(0, 1, 8'd0, 8'h0C, 0, 0, 8'h00);
      issue(0, 1, 8'd1, 8'h20, 0, 0, 8'h00);
      issue(0, 1, 8'd2, 8'h0A, 0, 0, 8'h00);
      issue(0, 0, 8'd0, 8'h00, 1, 0, 8'h0C);
      issue(0, 0, 8'd1, 8'h00, 1, 0, 8'h20);
      issue(0, 0, 8'd2, 8'h00, 1, 0, 8'h0A);

      issue(0, 1, 8'd17, 8'h40, 0, 0, 8'h00);
      issue(0, 0, 8'd17, 8'h00, 1, 0, 8'h40);

      // 200-word instance: out-of-range accesses flag err, 199 is valid
      issue(1, 1, 8'd210, 8'hFF, 0, 1, 8'h00);
      issue(1, 0, 8'd210, 8'h00, 1, 1, 8'h00);
      issue(1, 1, 8'd199, 8'h5A, 0, 0, 8'h00);
      issue(1, 0, 8'd199, 8'h00, 1, 0, 8'h5A);
      issue(1, 0, 8'd0,   8'h00, 1, 0, 8'h00);

      // clear_start beats a simultaneous read; second clear_start mid-sweep is ignored
      @(posedge clk); #1;
      a_clr = 1'b1; a_valid = 1'b1; req_write = 1'b0; req_addr = 8'd3;
      @(negedge clk);
      chk("A_ready_with_clear_start", a_ready, 0);
      @(posedge clk); #1;
      a_clr = 1'b0; a_valid = 1'b0;
      sweep_count(n, 50);
      chk("A_sweep_len_with_restart_attempt", n, 256);
      @(posedge clk); #1;
      issue(0, 0, 8'd17, 8'h00, 1, 0, 8'hA5);
      issue(0, 0, 8'd2,  8'h00, 1, 0, 8'hA5);

      // Reset at sweep cycle 100, held 3 cycles, then a fresh full sweep
      @(posedge clk); #1 a_clr = 1'b1;
      @(posedge clk); #1 a_clr = 1'b0;
      repeat (100) @(negedge clk);
      chk("A_busy_before_mid_reset", a_busy, 1);
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk_reset_a();
      end
      @(posedge clk); #1 rst_n = 1'b1;
      sweep_count(n, 0);
      chk("A_sweep_len_after_mid_reset", n, 256);
      @(posedge clk); #1;
      issue(0, 0, 8'd5,   8'h00, 1, 0, 8'hA5);
      issue(0, 0, 8'd255, 8'h00, 1, 0, 8'hA5);

      repeat (3) @(negedge clk);
      chk("A_queue_drained", qa.size(), 0);
      chk("B_queue_drained", qb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_mem_seq.md
# data_mem_seq

Parametrised single-port data memory with a valid/ready request interface, registered reads, and a sequential clear engine. It sweeps the array one word per cycle after reset and on command. It replaces the fixed 8x256 data memory in the datapath and sits between the load/store unit and the memory array. Width, depth and clear value are set per instance.

## Interface
- DATA_W, 8, data word width in bits
- ADDR_W, 8, address width in bits
- DEPTH, 256, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_W
- CLR_VAL, 0, DATA_W-bit value written to every word by the clear engine

- Clk  input  1  rising-edge clock; the only clock
- Reset  input  1  asynchronous, active-low reset (0 = in reset)
- req_valid  input  1  request present this cycle
- req_ready  output  1  block accepts a request this cycle
- req_write  input  1  1 = write, 0 = read; sampled with req_valid
- req_addr  input  ADDR_W  word address
- req_wdata  input  DATA_W  write data
- rd_valid  output  1  one-cycle pulse: rd_data holds the result of a read accepted on the previous edge
- rd_data  output  DATA_W  registered read data; holds its value between reads
- err  output  1  one-cycle pulse: the request accepted on the previous edge had req_addr >= DEPTH
- clear_start  input  1  start a full-array clear; honoured only in IDLE
- busy  output  1  clear engine active
- clear_done  output  1  one-cycle pulse when a clear sweep completes

## Operation
- FSM states:
  - CLEAR: sweep; clr_addr counts 0..DEPTH-1 and writes CLR_VAL to one word per edge.
  - IDLE: serve requests.
- Reset asserted (Reset=0), asynchronously:
  - state=CLEAR, clr_addr=0.
  - rd_valid=0, rd_data=0, err=0, clear_done=0.
  - busy=1, req_ready=0.
  - Array contents are not touched while Reset=0.
- CLEAR behaviour:
  - Each edge writes CLR_VAL to Core[clr_addr], then increments clr_addr.
  - On the edge that writes DEPTH-1: state moves to IDLE, clr_addr returns to 0, and clear_done is registered high for one cycle.
- IDLE behaviour:
  - clear_start=1 moves the FSM to CLEAR on the next edge.
  - clear_start in CLEAR is ignored; it does not restart or extend the sweep.
- busy = (state==CLEAR); combinational from state.
- req_ready = (state==IDLE) && !clear_start.
  - A clear request wins over a simultaneous access.
  - The access is not accepted; the requester holds it.
- Accept condition: req_valid && req_ready at a rising edge.
- Write, in range (req_addr < DEPTH): Core[req_addr] <= req_wdata. rd_valid stays 0.
- Read, in range: rd_data <= Core[req_addr]; rd_valid pulses next cycle.
- Out of range (req_addr >= DEPTH):
  - Write is dropped.
  - Read returns rd_data=0 with rd_valid=1.
  - err pulses in both cases.
- rd_valid, err and clear_done are single-cycle pulses, deasserted on every edge that does not set them.
- rd_data changes only on an accepted read, or on reset.
- Reset asserted mid-sweep or mid-access: the FSM returns to CLEAR with clr_addr=0. After release, a full DEPTH-cycle sweep runs again.

## Timing
- Read latency: 1 cycle. A read accepted at edge N gives rd_valid=1 and valid rd_data after edge N, sampled at edge N+1.
- Back-to-back accepted requests are allowed every cycle, giving a throughput of 1 access per cycle.
- Write-then-read of the same address on consecutive cycles returns the new data. The write commits at edge N, the read samples at edge N+1.
- Clear sweep duration: exactly DEPTH edges.
  - Reset release: first sweep write occurs at the first edge after Reset goes high.
  - clear_start accepted at edge N: sweep writes happen at edges N+1..N+DEPTH.
  - busy is high from after edge N through edge N+DEPTH.
  - After edge N+DEPTH: busy=0 and clear_done=1 in the same cycle, and req_ready may be 1 in that cycle.
- A read accepted in the last IDLE cycle before a clear still produces its rd_valid pulse. That pulse may coincide with the first CLEAR cycle.
- No combinational path from req_* to rd_data, rd_valid or err. req_ready depends combinationally only on state and clear_start.

## Test plan
- Reset, then release with DEPTH=256, CLR_VAL=8'hA5:
  - Required: busy=1 for exactly 256 cycles, then one clear_done pulse.
  - Reads of addresses 0, 128 and 255 then return 8'hA5 with rd_valid one cycle after acceptance.
- Back-to-back access:
  - Write 8'h0C to addr 0, 8'h20 to addr 1 and 8'h0A to addr 2 on consecutive cycles.
  - Then read 0, 1, 2 on consecutive cycles.
  - Required: rd_data is 8'h0C, 8'h20, 8'h0A on consecutive rd_valid cycles, with no bubbles.
- Write 8'h40 to addr 17, then read addr 17 on the very next cycle -> rd_data=8'h40.
- Instance with DEPTH=200:
  - Write 8'hFF to addr 210, then read addr 210.
  - Required: err pulses after each access; the read returns 8'h00 with rd_valid=1.
  - Addr 199 remains readable without err.
- Clear collisions:
  - Assert clear_start together with req_valid in IDLE -> req_ready=0 that cycle, the request is not accepted, and busy=1 next cycle.
  - Assert clear_start again mid-sweep -> the sweep still ends after 256 cycles total.
- Reset mid-sweep:
  - Pull Reset low at sweep cycle 100, release after 3 cycles.
  - Required: busy=1 and req_ready=0 during reset, rd_valid=0, and a fresh 256-cycle sweep followed by clear_done.
